// File: rtl/console_port_tx.sv
// Console-side NES/SNES pad emulator: latches an active-low button word and shifts it out per console clock.
// Optional idle timeout back to IDLE is compiled in with `define CONSOLE_PORT_TIMEOUT_EN.
module console_port_tx #(
    parameter int          SNES_MODE      = 0,
    parameter int          SYNC_STAGES    = 2,
    parameter logic        FILL_BIT       = 1'b0,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [7:0] buttons_in,
    input  logic [3:0] ext_in,
    input  logic       latch_in,
    input  logic       pclk_in,
    output logic       data_out,
    output logic       active_out,
    output logic       frame_done_out
);

    localparam int W  = (SNES_MODE != 0) ? 16 : 8;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state, state_n;
    logic [W-1:0]        shreg, shreg_n, word;
    logic [CW-1:0]       cnt, cnt_n;
    logic                data_n, done_n;
    logic [SYNC_STAGES-1:0] latch_sync, pclk_sync;
    logic                pclk_d;
    logic                latch_s, pclk_s, pclk_rise, timeout_hit;

    generate
        if (SNES_MODE != 0) begin : g_snes
            assign word = {4'b1111, ext_in, buttons_in};
        end else begin : g_nes
            logic [3:0] unused_ext;
            assign unused_ext = ext_in;
            assign word       = buttons_in;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            latch_sync <= '0;
            pclk_sync  <= '0;
            pclk_d     <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
            pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], pclk_in};
            pclk_d     <= pclk_s;
        end
    end

    assign latch_s   = latch_sync[SYNC_STAGES-1];
    assign pclk_s    = pclk_sync[SYNC_STAGES-1];
    assign pclk_rise = pclk_s & ~pclk_d;

`ifdef CONSOLE_PORT_TIMEOUT_EN
    logic        latch_d;
    logic [23:0] idle_cnt;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            latch_d  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            latch_d <= latch_s;
            if (latch_s && !latch_d)
                idle_cnt <= '0;
            else if (idle_cnt != TIMEOUT_CYCLES)
                idle_cnt <= idle_cnt + 24'd1;
        end
    end

    assign timeout_hit = (idle_cnt == TIMEOUT_CYCLES);
`else
    localparam logic [23:0] unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        done_n  = 1'b0;
        if (latch_s) begin
            // Latch wins everywhere: transparent reload, aborting any frame in flight.
            state_n = LOAD;
            shreg_n = word;
            cnt_n   = '0;
        end else if (timeout_hit) begin
            state_n = IDLE;
        end else if (state == LOAD || state == SHIFT) begin
            state_n = SHIFT;
            if (pclk_rise && cnt != LAST) begin
                shreg_n = {1'b1, shreg[W-1:1]};
                cnt_n   = cnt + CW'(1);
                if (cnt_n == LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end
            end
        end

        case (state_n)
            IDLE:    data_n = 1'b1;
            DONE:    data_n = FILL_BIT;
            default: data_n = shreg_n[0];
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state          <= IDLE;
            shreg          <= '1;
            cnt            <= '0;
            data_out       <= 1'b1;
            frame_done_out <= 1'b0;
        end else begin
            state          <= state_n;
            shreg          <= shreg_n;
            cnt            <= cnt_n;
            data_out       <= data_n;
            frame_done_out <= done_n;
        end
    end

    assign active_out = (state == LOAD) || (state == SHIFT);

endmodule

// File: tb/tb_console_port_tx.sv
// Directed bench for console_port_tx: NES and SNES frames, abort, held latch, timeout and async reset.
module tb_console_port_tx;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic [7:0] buttons_in;
    logic [3:0] ext_in;
    logic       latch_in, pclk_in, latch_to, pclk_to;
    logic       nes_data, nes_active, nes_fd;
    logic       snes_data, snes_active, snes_fd;
    logic       to_data, to_active, to_fd;

    int n_assert  = 0;
    int n_fail    = 0;
    int nes_done  = 0;
    int snes_done = 0;
    int to_done   = 0;

    always #5 clk_in = ~clk_in;

    console_port_tx #(.SNES_MODE(0)) dut_nes (
        .clk_in(clk_in), .reset_in(reset_in), .buttons_in(buttons_in), .ext_in(ext_in),
        .latch_in(latch_in), .pclk_in(pclk_in), .data_out(nes_data),
        .active_out(nes_active), .frame_done_out(nes_fd)
    );

    console_port_tx #(.SNES_MODE(1)) dut_snes (
        .clk_in(clk_in), .reset_in(reset_in), .buttons_in(buttons_in), .ext_in(ext_in),
        .latch_in(latch_in), .pclk_in(pclk_in), .data_out(snes_data),
        .active_out(snes_active), .frame_done_out(snes_fd)
    );

    console_port_tx #(.SNES_MODE(0), .TIMEOUT_CYCLES(24'd100)) dut_to (
        .clk_in(clk_in), .reset_in(reset_in), .buttons_in(buttons_in), .ext_in(ext_in),
        .latch_in(latch_to), .pclk_in(pclk_to), .data_out(to_data),
        .active_out(to_active), .frame_done_out(to_fd)
    );

    always @(posedge clk_in) begin
        if (nes_fd)  nes_done  <= nes_done + 1;
        if (snes_fd) snes_done <= snes_done + 1;
        if (to_fd)   to_done   <= to_done + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b0; latch_in = 1'b0; pclk_in = 1'b0; latch_to = 1'b0; pclk_to = 1'b0;
        buttons_in = 8'hFF; ext_in = 4'hF;
        step(3);
        n_assert++; if (nes_data !== 1'b1) begin n_fail++; $display("FAIL reset_nes_data got %b want 1", nes_data); end
        n_assert++; if (nes_active !== 1'b0) begin n_fail++; $display("FAIL reset_nes_active got %b want 0", nes_active); end
        n_assert++; if (nes_fd !== 1'b0) begin n_fail++; $display("FAIL reset_nes_done got %b want 0", nes_fd); end
        n_assert++; if (snes_data !== 1'b1) begin n_fail++; $display("FAIL reset_snes_data got %b want 1", snes_data); end
        reset_in = 1'b1;
        step(4);
        n_assert++; if (nes_data !== 1'b1) begin n_fail++; $display("FAIL idle_nes_data got %b want 1", nes_data); end
        n_assert++; if (nes_active !== 1'b0) begin n_fail++; $display("FAIL idle_nes_active got %b want 0", nes_active); end
    endtask

    task automatic test_nes();
        logic [7:0] b;
        logic       d2, d3, exp_bit, exp_done;
        int         base;
        b = 8'hA5; buttons_in = b; ext_in = 4'h0;
        base = nes_done;
        latch_in = 1'b1; step(12); latch_in = 1'b0; step(6);
        n_assert++; if (nes_active !== 1'b1) begin n_fail++; $display("FAIL nes_active got %b want 1", nes_active); end
        n_assert++; if (nes_data !== b[0]) begin n_fail++; $display("FAIL nes_bit0 got %b want %b", nes_data, b[0]); end
        for (int k = 1; k <= 9; k++) begin
            pclk_in = 1'b1; step(2); d2 = nes_fd; step(1); d3 = nes_fd; step(3);
            exp_bit  = (k < 8) ? b[k] : 1'b0;
            exp_done = (k == 8) ? 1'b1 : 1'b0;
            n_assert++; if (nes_data !== exp_bit) begin n_fail++; $display("FAIL nes_edge%0d data got %b want %b", k, nes_data, exp_bit); end
            n_assert++; if (d3 !== exp_done) begin n_fail++; $display("FAIL nes_edge%0d done_at_3 got %b want %b", k, d3, exp_done); end
            if (k == 8) begin
                n_assert++; if (d2 !== 1'b0) begin n_fail++; $display("FAIL nes_done_early got %b want 0", d2); end
            end
            pclk_in = 1'b0; step(6);
        end
        n_assert++; if (nes_done - base !== 1) begin n_fail++; $display("FAIL nes_done_count got %0d want 1", nes_done - base); end
        n_assert++; if (nes_active !== 1'b0) begin n_fail++; $display("FAIL nes_active_done got %b want 0", nes_active); end
    endtask

    task automatic test_snes();
        logic [15:0] w;
        logic        exp_bit;
        int          base;
        buttons_in = 8'h00; ext_in = 4'hA;
        w = 16'hFA00;
        base = snes_done;
        latch_in = 1'b1; step(12); latch_in = 1'b0; step(6);
        n_assert++; if (snes_data !== w[0]) begin n_fail++; $display("FAIL snes_bit0 got %b want %b", snes_data, w[0]); end
        for (int k = 1; k <= 16; k++) begin
            pclk_in = 1'b1; step(6);
            exp_bit = (k < 16) ? w[k] : 1'b0;
            n_assert++; if (snes_data !== exp_bit) begin n_fail++; $display("FAIL snes_edge%0d data got %b want %b", k, snes_data, exp_bit); end
            pclk_in = 1'b0; step(6);
        end
        n_assert++; if (snes_done - base !== 1) begin n_fail++; $display("FAIL snes_done_count got %0d want 1", snes_done - base); end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        logic       exp_bit;
        int         base;
        buttons_in = 8'h0F; ext_in = 4'h0;
        base = nes_done;
        latch_in = 1'b1; step(12); latch_in = 1'b0; step(6);
        for (int k = 0; k < 3; k++) begin
            pclk_in = 1'b1; step(6); pclk_in = 1'b0; step(6);
        end
        b = 8'h3C; buttons_in = b;
        latch_in = 1'b1; step(12);
        n_assert++; if (nes_done - base !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", nes_done - base); end
        n_assert++; if (nes_data !== b[0]) begin n_fail++; $display("FAIL abort_reload got %b want %b", nes_data, b[0]); end
        n_assert++; if (nes_active !== 1'b1) begin n_fail++; $display("FAIL abort_active got %b want 1", nes_active); end
        latch_in = 1'b0; step(6);
        buttons_in = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            pclk_in = 1'b1; step(6);
            exp_bit = (k < 8) ? b[k] : 1'b0;
            n_assert++; if (nes_data !== exp_bit) begin n_fail++; $display("FAIL abort_edge%0d data got %b want %b", k, nes_data, exp_bit); end
            pclk_in = 1'b0; step(6);
        end
        n_assert++; if (nes_done - base !== 1) begin n_fail++; $display("FAIL abort_done_count got %0d want 1", nes_done - base); end
    endtask

    task automatic test_latch_held();
        logic [7:0] vals [4];
        logic [7:0] v;
        int         base;
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'hFE;
        base = nes_done;
        latch_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = vals[i]; buttons_in = v;
            pclk_in = 1'b1; step(5);
            n_assert++; if (nes_data !== v[0]) begin n_fail++; $display("FAIL held%0d data got %b want %b", i, nes_data, v[0]); end
            pclk_in = 1'b0; step(5);
        end
        latch_in = 1'b0; step(6);
        n_assert++; if (nes_data !== v[0]) begin n_fail++; $display("FAIL held_release got %b want %b", nes_data, v[0]); end
        pclk_in = 1'b1; step(6);
        n_assert++; if (nes_data !== v[1]) begin n_fail++; $display("FAIL held_first_shift got %b want %b", nes_data, v[1]); end
        pclk_in = 1'b0; step(6);
        n_assert++; if (nes_done - base !== 0) begin n_fail++; $display("FAIL held_no_done got %0d want 0", nes_done - base); end
    endtask

    task automatic test_timeout();
        int   base;
        logic exp_data;
        buttons_in = 8'hA5;
        base = to_done;
        latch_to = 1'b1; step(4); latch_to = 1'b0; step(4);
        for (int k = 0; k < 8; k++) begin
            pclk_to = 1'b1; step(2); pclk_to = 1'b0; step(2);
        end
        step(10);
        n_assert++; if (to_data !== 1'b0) begin n_fail++; $display("FAIL to_fill got %b want 0", to_data); end
        n_assert++; if (to_done - base !== 1) begin n_fail++; $display("FAIL to_done_count got %0d want 1", to_done - base); end
        step(100);
`ifdef CONSOLE_PORT_TIMEOUT_EN
        exp_data = 1'b1;
`else
        exp_data = 1'b0;
`endif
        n_assert++; if (to_data !== exp_data) begin n_fail++; $display("FAIL to_after_idle data got %b want %b", to_data, exp_data); end
        n_assert++; if (to_active !== 1'b0) begin n_fail++; $display("FAIL to_after_idle active got %b want 0", to_active); end
        n_assert++; if (to_done - base !== 1) begin n_fail++; $display("FAIL to_no_extra_done got %0d want 1", to_done - base); end
    endtask

    task automatic test_reset_mid();
        buttons_in = 8'h00;
        latch_in = 1'b1; step(12); latch_in = 1'b0; step(6);
        for (int k = 0; k < 3; k++) begin
            pclk_in = 1'b1; step(6); pclk_in = 1'b0; step(6);
        end
        n_assert++; if (nes_active !== 1'b1) begin n_fail++; $display("FAIL mid_active_pre got %b want 1", nes_active); end
        #2 reset_in = 1'b0;
        #1;
        n_assert++; if (nes_data !== 1'b1) begin n_fail++; $display("FAIL mid_reset_data got %b want 1", nes_data); end
        n_assert++; if (nes_active !== 1'b0) begin n_fail++; $display("FAIL mid_reset_active got %b want 0", nes_active); end
        n_assert++; if (nes_fd !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done got %b want 0", nes_fd); end
        step(2); reset_in = 1'b1; step(2);
    endtask

    initial begin
        test_reset();
        test_nes();
        test_snes();
        test_abort();
        test_latch_held();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/console_port_tx.md
Name: console_port_tx

Overview:
- Console-side end of the controller path: emulates an NES or SNES pad shift register toward a real console.
- Takes an active-low button byte (one of the router's NES/SNES outputs) and captures it on the console's latch.
- Shifts the captured word out serially, one bit per console clock pulse.
- One instance per console port (NES0/NES1/SNES0/SNES1). All console-side signals are asynchronous to clk_in and are synchronized internally.

Parameters:
- SNES_MODE, 0: 0 selects an 8-bit NES word; 1 selects a 16-bit SNES word.
- SYNC_STAGES, 2: number of synchronizer flops on latch_in and pclk_in (legal range 2..4).
- FILL_BIT, 1'b0: value driven on data_out after all word bits have been shifted.
- TIMEOUT_CYCLES, 24'd1_000_000: idle timeout in clk_in cycles; used only with the optional feature.

Ports:
- clk_in, input, 1: system clock.
- reset_in, input, 1: asynchronous active-low reset.
- buttons_in, input, 8: active-low buttons; bit0 is shifted first (NES order A,B,Select,Start,Up,Down,Left,Right).
- ext_in, input, 4: active-low extra SNES buttons (word bits 8..11); ignored when SNES_MODE=0.
- latch_in, input, 1: console latch, asynchronous, active-high.
- pclk_in, input, 1: console data clock, asynchronous; a rising edge advances one bit.
- data_out, output, 1: serial data to the console.
- active_out, output, 1: high while in LOAD or SHIFT.
- frame_done_out, output, 1: one-cycle pulse when the last word bit has been consumed.

Behaviour:
- Reset values (reset_in low):
  - data_out=1, active_out=0, frame_done_out=0.
  - State IDLE; shift register all-ones; bit counter 0; synchronizers cleared to 0.
- Synchronization:
  - latch_s and pclk_s are the outputs of the SYNC_STAGES flop chains.
  - Edges are detected against one extra registered copy.
  - Input-to-effect latency is SYNC_STAGES+1 clk_in cycles.
- Word width and contents:
  - W=8 when SNES_MODE=0; word = buttons_in.
  - W=16 when SNES_MODE=1; word = {4'b1111, ext_in, buttons_in}. Bits 12..15 are the ID nibble, driven high.
- data_out is registered: it equals shreg[0] in LOAD/SHIFT, FILL_BIT in DONE, and 1 in IDLE.
- States:
  - IDLE: entered from reset. latch_s high -> LOAD.
  - LOAD: shreg reloads from the word every cycle while latch_s is high (transparent parallel load); counter=0. latch_s low -> SHIFT.
  - SHIFT: on each pclk_s rising edge with latch_s low, shreg shifts right (fill 1) and counter increments. When the counter reaches W, go to DONE and pulse frame_done_out for one cycle.
  - DONE: data_out=FILL_BIT. Further pclk edges are ignored. latch_s high -> LOAD.
- Boundary conditions:
  - latch_s high in any state -> LOAD immediately. An in-progress frame is aborted with no frame_done_out; the counter is cleared.
  - A pclk_s rising edge in a cycle where latch_s is high is ignored.
  - A pclk_s rising edge in the same cycle latch_s falls: latch_s is low that cycle, so the edge counts as the first shift.
  - buttons_in changes after latch_s falls do not affect the frame in flight.
  - Counter width is clog2(W+1); no wrap: the counter saturates at W.
  - An asynchronous reset mid-frame returns all reset values immediately.

Optional Feature:
- Macro CONSOLE_PORT_TIMEOUT_EN.
- Defined:
  - A 24-bit idle counter clears on every latch_s rising edge and increments otherwise, saturating at TIMEOUT_CYCLES.
  - At TIMEOUT_CYCLES the block forces IDLE: data_out=1, active_out=0, no frame_done_out pulse.
  - Covers a powered-off or unplugged console.
- Not defined: no idle counter; DONE persists indefinitely until the next latch.

Test Plan:
- Reset with latch_in/pclk_in low -> data_out=1, active_out=0, frame_done_out=0, state IDLE.
- SNES_MODE=0, buttons_in=8'hA5, latch pulse of 12 cycles, then 8 pclk pulses of 6 cycles high/6 low:
  - data_out after latch falls, and after each pclk edge, shows 1,0,1,0,0,1,0,1.
  - frame_done_out pulses once, 3 cycles after the 8th edge (SYNC_STAGES+1).
  - A 9th pclk edge leaves data_out=0 (FILL_BIT).
- SNES_MODE=1, buttons_in=8'h00, ext_in=4'hA, 16 pclk edges:
  - Serial sequence is eight 0s, then 0,1,0,1, then 1,1,1,1.
  - frame_done_out pulses after edge 16.
- Abort: latch raised again after 3 of 8 edges -> no frame_done_out; the new buttons_in value is reloaded; the following 8 edges give a full frame.
- pclk toggled while latch_in held high for 40 cycles -> no shifts; data_out tracks buttons_in[0] as it changes.
- With CONSOLE_PORT_TIMEOUT_EN and TIMEOUT_CYCLES=100: no latch for 100 cycles after DONE -> data_out=1, active_out=0.
  - Without the macro, data_out stays at FILL_BIT.
